wb_sched: RTL
=============

# wb_sched

Writeback scheduler for the dual-issue pipeline. Two execution lanes retire writebacks into one shared register-file write port. The block does the following:
- selects each lane's result (load vs ALU);
- drops the older write when both lanes target the same register in the same cycle;
- buffers writes in a multi-push FIFO and drains one write per cycle, in program order;
- exports a per-register pending mask for issue-stage hazard checks.

It sits between the execute/memory stages and the register-file write port.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥ 2
- DW, 16: data width
- AW, 3: register address width (8 registers)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- lane0_valid  in  1  lane 0 (older instruction) requests a writeback
- lane0_isld  in  1  1 selects lane0_ldresult, 0 selects lane0_aluresult
- lane0_instr  in  16  instruction word; destination register is instr[7:5]
- lane0_ldresult  in  DW  load result
- lane0_aluresult  in  DW  ALU result
- lane1_valid, lane1_isld, lane1_instr, lane1_ldresult, lane1_aluresult  in  same widths as lane 0  lane 1 (younger instruction)
- in_ready  out  1  both lanes may push this cycle
- wr_en  out  1  head entry valid on write port
- wr_addr  out  AW  head destination register
- wr_data  out  DW  head data
- wr_ready  in  1  register file accepts the write this cycle
- pending  out  8  bit r set while any queued entry targets register r
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- **in_ready**: (DEPTH − count) ≥ 2, decoded from the count register only. A pop in the same cycle does not raise it.
- **Push**: occurs only when in_ready=1.
  - If in_ready=0, upstream holds the valids and payloads stable. Valids are ignored.
- **Per-lane entry**: {addr = instr[7:5], data = isld ? ldresult : aluresult}.
- **Push cases**:
  - Neither lane valid: nothing pushed.
  - One lane valid: push that lane's entry.
  - Both valid, different addr: push lane0 then lane1 (lane0 at tail, lane1 at tail+1).
  - Both valid, same addr: push lane1 only; lane0's write is discarded.
- **Pop**: when wr_en & wr_ready, the head advances.
- **Write port**: wr_en = (count ≠ 0). wr_addr and wr_data come from the head entry. When wr_en=0, wr_addr and wr_data are 0.
- **Count update**: count_next = count + pushes − pop. Simultaneous push and pop are legal. Overflow cannot occur under the in_ready rule.
- **Pointers**: $clog2(DEPTH) bits, wrapping modulo DEPTH.
- **pending**: OR of decoded addr over valid entries. It is combinational from storage flops and excludes the current-cycle inputs.
- **FIFO states**: EMPTY (count=0), PARTIAL, NEARFULL (DEPTH−count < 2).
  - These are derived from count; no separate state register.

## Timing
- **Reset**: while rst_n=0, and immediately on assertion:
  - count=0, pointers=0;
  - wr_en=0, wr_addr=0, wr_data=0;
  - pending=0, in_ready=1.
  - Reset mid-operation discards all queued entries, including an entry presented on the port that same cycle.
- **Latency**: an entry pushed at edge N is visible on wr_* in cycle N+1 if the FIFO was empty. Minimum latency is 1 cycle.
- **Drain rate**: one write per cycle with wr_ready held high. Two lanes pushing every cycle therefore throttle in_ready.
- **Drain order**: strictly FIFO. For one destination, the register file sees writes in program order.
- **Stall**: wr_ready=0 holds the head, and wr_* stays stable.

## Structure
- **Package wb_pkg**:
  - wb_entry_t {logic [AW-1:0] addr; logic [DW-1:0] data;};
  - constants DW=16, AW=3, NREG=8;
  - function dest_of(instr) returning instr[7:5].
- **Sub-module wb_fifo**: 2-push/1-pop FIFO with ports push_cnt[1:0], push0, push1, pop, head, count, and the valid-entry vector.
- **wb_sched top**: result muxing, same-destination coalescing, in_ready, and the pending decode.

## Test plan
- **Reset**: assert rst_n=0 with 3 entries queued → wr_en=0, count=0, pending=0 and in_ready=1 immediately; after release, no stale writes appear.
- **Single push**: lane0 valid, isld=0, instr[7:5]=3, aluresult=16'h1234, wr_ready=1 → next cycle wr_en=1, wr_addr=3, wr_data=16'h1234, pending=8'h08; the cycle after, count=0.
- **Dual push**:
  - Stimulus: lane0 to r1 with ldresult=16'hAAAA, isld=1; lane1 to r2 with aluresult=16'h5555; same cycle.
  - Response: writes appear in order r1:AAAA, then r2:5555, on consecutive cycles.
- **Coalesce**: both lanes target r5, lane0=16'h0001, lane1=16'h0002 → exactly one write, r5=16'h0002, and count increments by 1.
- **Back-pressure**: wr_ready=0 with dual pushes each cycle, DEPTH=4.
  - After 1 cycle, count=2 and in_ready stays 1; after the 2nd push, count=4 and in_ready=0.
  - Held inputs are not pushed.
  - Then raise wr_ready → one pop per cycle; in_ready returns to 1 when count=2.
- **Wrap-around**: 12 alternating single and dual pushes with random wr_ready → the write sequence matches the reference model exactly, and pending matches the queue contents every cycle.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared types, widths and helpers for the writeback scheduler.
package wb_pkg;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NREG = 8;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;
  typedef enum logic [1:0] {EMPTY, PARTIAL, NEARFULL} fifo_state_t;
  function automatic logic [AW-1:0] dest_of(input logic [15:0] instr);
    return instr[7:5];
  endfunction
endpackage

// File: rtl/wb_sched_if.sv
// wb_sched_if: lane writeback inputs, register-file write port and hazard outputs.
interface wb_sched_if #(parameter int DEPTH = 4, parameter int DW = 16, parameter int AW = 3);
  logic                     lane0_valid, lane0_isld;
  logic [15:0]              lane0_instr;
  logic [DW-1:0]            lane0_ldresult, lane0_aluresult;
  logic                     lane1_valid, lane1_isld;
  logic [15:0]              lane1_instr;
  logic [DW-1:0]            lane1_ldresult, lane1_aluresult;
  logic                     in_ready;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [DW-1:0]            wr_data;
  logic                     wr_ready;
  logic [7:0]               pending;
  logic [$clog2(DEPTH):0]   count;
  modport slave (
    input  lane0_valid, lane0_isld, lane0_instr, lane0_ldresult, lane0_aluresult,
    input  lane1_valid, lane1_isld, lane1_instr, lane1_ldresult, lane1_aluresult,
    input  wr_ready,
    output in_ready, wr_en, wr_addr, wr_data, pending, count
  );
  modport master (
    output lane0_valid, lane0_isld, lane0_instr, lane0_ldresult, lane0_aluresult,
    output lane1_valid, lane1_isld, lane1_instr, lane1_ldresult, lane1_aluresult,
    output wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data, pending, count
  );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: 2-push/1-pop circular FIFO of writeback entries.
module wb_fifo import wb_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              push_cnt,
  input  wb_entry_t               push0,
  input  wb_entry_t               push1,
  input  logic                    pop,
  output wb_entry_t               head,
  output logic [CW-1:0]           count,
  output logic [DEPTH-1:0]        valid,
  output wb_entry_t [DEPTH-1:0]   entries
);
  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push_cnt != 2'd0) mem_d[wr_ptr_q] = push0;
    if (push_cnt == 2'd2) mem_d[wr_ptr_q + PW'(1)] = push1;
    wr_ptr_d = wr_ptr_q + PW'(push_cnt);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d = count_q + CW'(push_cnt) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  // slot i is live when its distance from the read pointer is below count
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) valid[i] = {1'b0, PW'(i) - rd_ptr_q} < count_q;
  end
  assign head = mem_q[rd_ptr_q];
  assign count = count_q;
  assign entries = mem_q;
endmodule

// File: rtl/wb_sched.sv
// wb_sched: merges two lanes' writebacks into one in-order register-file write port.
module wb_sched import wb_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int DW = wb_pkg::DW,
  parameter int AW = wb_pkg::AW
) (
  input logic      clk,
  input logic      rst_n,
  wb_sched_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  wb_entry_t e0, e1, push0, head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0] valid;
  logic [CW-1:0] count;
  logic [1:0] push_cnt;
  logic same, pop;
  fifo_state_t state;
  always_comb begin
    a0 = dest_of(bus.lane0_instr);
    a1 = dest_of(bus.lane1_instr);
    d0 = bus.lane0_isld ? bus.lane0_ldresult : bus.lane0_aluresult;
    d1 = bus.lane1_isld ? bus.lane1_ldresult : bus.lane1_aluresult;
    e0 = '{addr: a0, data: d0};
    e1 = '{addr: a1, data: d1};
    state = (count == '0) ? EMPTY : (CW'(DEPTH) - count < CW'(2)) ? NEARFULL : PARTIAL;
    bus.in_ready = state != NEARFULL;
    // younger lane wins a same-register collision, so lane0's write is dropped
    same = bus.lane0_valid & bus.lane1_valid & (a0 == a1);
    push_cnt = !bus.in_ready ? 2'd0 :
               (bus.lane0_valid & bus.lane1_valid & !same) ? 2'd2 :
               (bus.lane0_valid | bus.lane1_valid) ? 2'd1 : 2'd0;
    push0 = (bus.lane0_valid & !same) ? e0 : e1;
    bus.wr_en = state != EMPTY;
    pop = bus.wr_en & bus.wr_ready;
    bus.wr_addr = bus.wr_en ? head.addr : '0;
    bus.wr_data = bus.wr_en ? head.data : '0;
    bus.count = count;
    bus.pending = '0;
    for (int i = 0; i < DEPTH; i++) if (valid[i]) bus.pending[entries[i].addr] = 1'b1;
  end
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_cnt(push_cnt), .push0(push0), .push1(e1),
    .pop(pop), .head(head), .count(count), .valid(valid), .entries(entries)
  );
endmodule
